// File: rtl/coms_frame_rx_if.sv
// rtl/coms_frame_rx_if.sv - received byte stream from uart_rx into the frame receiver
interface coms_frame_rx_if;
   logic       rx_data_ready;
   logic [7:0] rx_data;

   modport master (output rx_data_ready, output rx_data);
   modport slave  (input  rx_data_ready, input  rx_data);
endinterface

// File: rtl/coms_frame_rx.sv
// rtl/coms_frame_rx.sv - magic-synced payload frame receiver with CRC16, ID filter, timeout and counters
module coms_frame_rx #(
   parameter logic [31:0] MAGIC_NUMBER   = 32'h1CEB00DA,
   parameter int          MAGIC_LENGTH   = 4,
   parameter int          PAYLOAD_LENGTH = 24,
   parameter int          TIMEOUT_CYCLES = 8334,
   parameter int          CNT_W          = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   coms_frame_rx_if.slave                rx,
   input  logic [7:0]                    expected_id,
   input  logic                          id_check_enable,
   output logic [8*PAYLOAD_LENGTH-1:0]   frame_data,
   output logic [7:0]                    frame_id,
   output logic                          frame_valid,
   output logic                          crc_error,
   output logic                          id_error,
   output logic                          timeout_error,
   output logic [CNT_W-1:0]              frame_count,
   output logic [CNT_W-1:0]              error_count,
   output logic                          busy
);
   localparam int MW = 8 * MAGIC_LENGTH;
   localparam int IW = $clog2(PAYLOAD_LENGTH + 2);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int BW = $clog2(8 * PAYLOAD_LENGTH);
   localparam logic [IW-1:0] IDX_HI = IW'(PAYLOAD_LENGTH);
   localparam logic [IW-1:0] IDX_LO = IW'(PAYLOAD_LENGTH + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {HUNT, RECEIVE, CHECK} state_t;

   state_t                      state, state_nxt;
   logic [MW-1:0]               cand;
   logic                        magic_hit;
   logic [IW-1:0]               idx;
   logic [BW-1:0]               boff;
   logic [TW-1:0]               tcnt;
   logic [15:0]                 crc;
   logic [15:0]                 crc_rx;
   logic [8*PAYLOAD_LENGTH-1:0] pbuf;
   logic                        timeout_hit;
   logic                        chk_crc_bad;
   logic                        chk_id_bad;
   logic                        chk_good;

   // CRC16 0x8005, one byte, MSB first (same result as nextCRC16_D8)
   function automatic logic [15:0] next_crc16_d8(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c;
      for (int i = 7; i >= 0; i--) begin
         r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h8005 : 16'h0000);
      end
      return r;
   endfunction

   // candidate window = previous MAGIC_LENGTH-1 bytes plus the byte arriving now
   generate
      if (MAGIC_LENGTH > 1) begin : g_shift
         logic [MW-9:0] shift;
         assign cand = {shift, rx.rx_data};
         // magic history shifts on every byte, whatever the state
         always_ff @(posedge clk) begin
            if (!reset) shift <= '0;
            else if (rx.rx_data_ready) shift <= cand[MW-9:0];
         end
      end else begin : g_noshift
         assign cand = rx.rx_data;
      end
   endgenerate

   assign magic_hit = rx.rx_data_ready && (cand == MAGIC_NUMBER[MW-1:0]);
   assign busy      = (state != HUNT);
   assign boff      = BW'({idx, 3'b000});

   // state register
   always_ff @(posedge clk) begin
      if (!reset) state <= HUNT;
      else        state <= state_nxt;
   end

   // next-state logic; a byte in the expiry cycle keeps the frame alive
   always_comb begin
      state_nxt = state;
      case (state)
         HUNT:    if (magic_hit) state_nxt = RECEIVE;
         RECEIVE: begin
            if (rx.rx_data_ready && idx == IDX_LO) state_nxt = CHECK;
            else if (timeout_hit)                  state_nxt = HUNT;
         end
         default: state_nxt = HUNT;
      endcase
   end

   // frame verdict decode; at most one of the three is set per frame
   always_comb begin
      timeout_hit = (state == RECEIVE) && !rx.rx_data_ready && (tcnt == T_LAST);
      chk_crc_bad = (state == CHECK) && (crc != crc_rx);
      chk_id_bad  = (state == CHECK) && (crc == crc_rx) && id_check_enable &&
                    (pbuf[7:0] != expected_id);
      chk_good    = (state == CHECK) && (crc == crc_rx) && !chk_id_bad;
   end

   // datapath: byte collection, CRC, timeout counter, registered status and counters
   always_ff @(posedge clk) begin
      if (!reset) begin
         idx           <= '0;
         tcnt          <= '0;
         crc           <= '0;
         crc_rx        <= '0;
         pbuf          <= '0;
         frame_data    <= '0;
         frame_id      <= '0;
         frame_valid   <= 1'b0;
         crc_error     <= 1'b0;
         id_error      <= 1'b0;
         timeout_error <= 1'b0;
         frame_count   <= '0;
         error_count   <= '0;
      end else begin
         frame_valid   <= chk_good;
         crc_error     <= chk_crc_bad;
         id_error      <= chk_id_bad;
         timeout_error <= timeout_hit;
         if (chk_good) begin
            frame_data <= pbuf;
            frame_id   <= pbuf[7:0];
            if (frame_count != '1) frame_count <= frame_count + 1'b1;
         end
         if ((chk_crc_bad || chk_id_bad || timeout_hit) && error_count != '1)
            error_count <= error_count + 1'b1;
         case (state)
            HUNT: begin
               if (magic_hit) begin
                  idx  <= '0;
                  tcnt <= '0;
                  crc  <= 16'hFFFF;
               end
            end
            RECEIVE: begin
               if (rx.rx_data_ready) begin
                  tcnt <= '0;
                  idx  <= idx + 1'b1;
                  if (idx < IDX_HI) begin
                     pbuf[boff +: 8] <= rx.rx_data;
                     crc             <= next_crc16_d8(crc, rx.rx_data);
                  end else if (idx == IDX_HI) begin
                     crc_rx[15:8] <= rx.rx_data;
                  end else begin
                     crc_rx[7:0]  <= rx.rx_data;
                  end
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_coms_frame_rx.sv
// tb/tb_coms_frame_rx.sv - randomized bench with byte-level reference model for coms_frame_rx
module tb_coms_frame_rx;
   localparam int          PL    = 24;
   localparam int          T     = 50;
   localparam int          ML    = 4;
   localparam logic [31:0] MAGIC = 32'h1CEB00DA;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] expected_id = 8'h00;
   logic       id_check_enable = 1'b0;

   coms_frame_rx_if rx ();
   coms_frame_rx_if rx_s ();
   assign rx_s.rx_data_ready = rx.rx_data_ready;
   assign rx_s.rx_data       = rx.rx_data;

   logic [8*PL-1:0] frame_data;
   logic [7:0]      frame_id;
   logic            frame_valid, crc_error, id_error, timeout_error, busy;
   logic [15:0]     frame_count, error_count;

   logic [8*PL-1:0] s_frame_data;
   logic [7:0]      s_frame_id;
   logic            s_frame_valid, s_crc_error, s_id_error, s_timeout_error, s_busy;
   logic [2:0]      s_frame_count, s_error_count;

   coms_frame_rx #(.MAGIC_NUMBER(MAGIC), .MAGIC_LENGTH(ML), .PAYLOAD_LENGTH(PL),
                   .TIMEOUT_CYCLES(T), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .rx(rx), .expected_id(expected_id),
      .id_check_enable(id_check_enable), .frame_data(frame_data), .frame_id(frame_id),
      .frame_valid(frame_valid), .crc_error(crc_error), .id_error(id_error),
      .timeout_error(timeout_error), .frame_count(frame_count),
      .error_count(error_count), .busy(busy));

   coms_frame_rx #(.MAGIC_NUMBER(MAGIC), .MAGIC_LENGTH(ML), .PAYLOAD_LENGTH(PL),
                   .TIMEOUT_CYCLES(T), .CNT_W(3)) dut_small (
      .clk(clk), .reset(reset), .rx(rx_s), .expected_id(expected_id),
      .id_check_enable(id_check_enable), .frame_data(s_frame_data), .frame_id(s_frame_id),
      .frame_valid(s_frame_valid), .crc_error(s_crc_error), .id_error(s_id_error),
      .timeout_error(s_timeout_error), .frame_count(s_frame_count),
      .error_count(s_error_count), .busy(s_busy));

   int total = 0;
   int bad = 0;
   int fv_seen = 0, ce_seen = 0, ie_seen = 0, te_seen = 0, busy_seen = 0;

   // reference model state (byte level)
   bit              armed = 1'b0;
   bit              m_in_frame = 1'b0, m_in_check = 1'b0;
   int              m_idle = 0, m_fc = 0, m_ec = 0;
   logic [7:0]      m_hist[$];
   logic [7:0]      m_frame[$];
   logic            e_fv = 1'b0, e_ce = 1'b0, e_ie = 1'b0, e_te = 1'b0;
   logic [8*PL-1:0] e_fdata = '0;
   logic [7:0]      e_fid = '0;

   logic [7:0] pay [PL];

   function automatic logic [15:0] crc16(input logic [7:0] q[$]);
      int c;
      int fb;
      c = 'hFFFF;
      foreach (q[i]) begin
         for (int b = 7; b >= 0; b--) begin
            fb = ((c >> 15) & 1) ^ ((q[i] >> b) & 1);
            c  = (c << 1) & 'hFFFF;
            if (fb != 0) c = c ^ 'h8005;
         end
      end
      return c[15:0];
   endfunction

   function automatic int sat(input int v, input int lim);
      return (v > lim) ? lim : v;
   endfunction

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // compare against the model, then advance the model by this cycle's inputs
   always @(negedge clk) begin
      logic [7:0]  p[$];
      logic [15:0] c;
      if (armed) begin
         chk("frame_valid", frame_valid, e_fv);
         chk("crc_error", crc_error, e_ce);
         chk("id_error", id_error, e_ie);
         chk("timeout_error", timeout_error, e_te);
         chk("busy", busy, m_in_frame || m_in_check);
         chk("frame_data", frame_data, e_fdata);
         chk("frame_id", frame_id, e_fid);
         chk("frame_count", frame_count, sat(m_fc, 65535));
         chk("error_count", error_count, sat(m_ec, 65535));
         chk("small_frame_count", s_frame_count, sat(m_fc, 7));
         chk("small_error_count", s_error_count, sat(m_ec, 7));
         if (frame_valid === 1'b1)   fv_seen++;
         if (crc_error === 1'b1)     ce_seen++;
         if (id_error === 1'b1)      ie_seen++;
         if (timeout_error === 1'b1) te_seen++;
         if (busy === 1'b1)          busy_seen++;
      end
      e_fv = 1'b0; e_ce = 1'b0; e_ie = 1'b0; e_te = 1'b0;
      if (!reset) begin
         armed = 1'b1;
         m_in_frame = 1'b0; m_in_check = 1'b0; m_idle = 0; m_fc = 0; m_ec = 0;
         m_hist.delete(); m_frame.delete();
         e_fdata = '0; e_fid = '0;
      end else begin
         if (rx.rx_data_ready) begin
            m_hist.push_back(rx.rx_data);
            if (m_hist.size() > ML) void'(m_hist.pop_front());
         end
         if (m_in_check) begin
            p.delete();
            for (int i = 0; i < PL; i++) p.push_back(m_frame[i]);
            c = crc16(p);
            if (c != {m_frame[PL], m_frame[PL+1]}) begin
               e_ce = 1'b1; m_ec++;
            end else if (id_check_enable && m_frame[0] != expected_id) begin
               e_ie = 1'b1; m_ec++;
            end else begin
               e_fv = 1'b1; m_fc++;
               for (int i = 0; i < PL; i++) e_fdata[8*i +: 8] = m_frame[i];
               e_fid = m_frame[0];
            end
            m_in_check = 1'b0;
         end else if (m_in_frame) begin
            if (rx.rx_data_ready) begin
               m_frame.push_back(rx.rx_data);
               m_idle = 0;
               if (m_frame.size() == PL + 2) begin
                  m_in_frame = 1'b0; m_in_check = 1'b1;
               end
            end else begin
               m_idle++;
               if (m_idle == T) begin
                  e_te = 1'b1; m_ec++; m_in_frame = 1'b0;
               end
            end
         end else if (rx.rx_data_ready && m_hist.size() == ML &&
                      {m_hist[0], m_hist[1], m_hist[2], m_hist[3]} == MAGIC) begin
            m_in_frame = 1'b1; m_frame.delete(); m_idle = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int rgap();
      return $urandom_range(0, 3);
   endfunction

   task automatic send_byte(input logic [7:0] b, input int gap);
      rx.rx_data_ready = 1'b1;
      rx.rx_data       = b;
      tick();
      rx.rx_data_ready = 1'b0;
      rx.rx_data       = 8'($urandom);
      repeat (gap) tick();
   endtask

   task automatic send_magic();
      logic [31:0] mg;
      mg = MAGIC;
      for (int i = 0; i < ML; i++) send_byte(mg[31-8*i -: 8], rgap());
   endtask

   task automatic send_partial(input int n);
      send_magic();
      for (int i = 0; i < n; i++) send_byte(pay[i], 0);
   endtask

   // flip: payload byte whose bit 0 is inverted on the wire; slow_at: byte followed by T-1 idle cycles
   task automatic send_frame(input int flip, input int slow_at);
      logic [7:0]  q[$];
      logic [15:0] c;
      logic [7:0]  b;
      for (int i = 0; i < PL; i++) q.push_back(pay[i]);
      c = crc16(q);
      send_magic();
      for (int i = 0; i < PL; i++) begin
         b = pay[i];
         if (i == flip) b = b ^ 8'h01;
         send_byte(b, (i == slow_at) ? T - 1 : rgap());
      end
      send_byte(c[15:8], rgap());
      send_byte(c[7:0], 0);
      repeat (4) tick();
   endtask

   task automatic set_pay_basic(input logic [7:0] id);
      pay[0] = id;
      for (int i = 1; i < PL; i++) pay[i] = 8'(i + 1);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] q9[$];
      int fv0, ce0, ie0, te0, mode;
      rx.rx_data_ready = 1'b0;
      rx.rx_data       = 8'h00;
      repeat (3) tick();
      reset = 1'b1;
      tick();

      for (int i = 0; i < 9; i++) q9.push_back(8'(8'h31 + i));
      chk("crc_check_value", crc16(q9), 16'hAEE7);
      chk("reset_busy", busy, 0);
      chk("reset_frame_count", frame_count, 0);
      chk("reset_frame_data", frame_data, 0);

      // valid frame
      expected_id = 8'h03; id_check_enable = 1'b1;
      set_pay_basic(8'h03);
      fv0 = fv_seen;
      send_frame(-1, -1);
      chk("t1_pulses", fv_seen - fv0, 1);
      chk("t1_frame_id", frame_id, 8'h03);
      chk("t1_byte1", frame_data[15:8], 8'h02);
      chk("t1_byte23", frame_data[191:184], 8'h18);
      chk("t1_frame_count", frame_count, 1);
      chk("t1_error_count", error_count, 0);

      // corrupted payload byte 5
      ce0 = ce_seen;
      send_frame(5, -1);
      chk("t2_crc_pulse", ce_seen - ce0, 1);
      chk("t2_data_held", frame_data[47:40], 8'h06);
      chk("t2_error_count", error_count, 1);

      // ID filter
      set_pay_basic(8'h05);
      expected_id = 8'h02;
      ie0 = ie_seen;
      send_frame(-1, -1);
      chk("t3_id_pulse", ie_seen - ie0, 1);
      id_check_enable = 1'b0;
      fv0 = fv_seen;
      send_frame(-1, -1);
      chk("t3_nocheck_valid", fv_seen - fv0, 1);
      chk("t3_frame_id", frame_id, 8'h05);

      // timeout, then a frame whose byte lands exactly at expiry
      te0 = te_seen;
      send_partial(10);
      repeat (T + 2) tick();
      chk("t4_timeout_pulse", te_seen - te0, 1);
      chk("t4_busy", busy, 0);
      te0 = te_seen; fv0 = fv_seen;
      send_frame(-1, 9);
      chk("t4_edge_no_timeout", te_seen - te0, 0);
      chk("t4_edge_valid", fv_seen - fv0, 1);

      // false start inside the magic, then noise
      fv0 = fv_seen;
      send_byte(8'h1C, 0);
      send_byte(8'hEB, 0);
      send_frame(-1, -1);
      chk("t5_resync_valid", fv_seen - fv0, 1);
      busy_seen = 0;
      for (int i = 0; i < 40; i++) send_byte(8'hFF, rgap());
      chk("t5_noise_busy", busy_seen, 0);

      // reset mid-frame
      set_pay_basic(8'h03);
      expected_id = 8'h03; id_check_enable = 1'b1;
      send_partial(12);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("t6_frame_count", frame_count, 0);
      chk("t6_error_count", error_count, 0);
      chk("t6_frame_data", frame_data, 0);
      chk("t6_busy", busy, 0);
      for (int i = 12; i < PL; i++) send_byte(pay[i], rgap());
      send_byte(8'h55, 0);
      send_byte(8'hAA, 2);
      chk("t6_tail_ignored", busy, 0);
      fv0 = fv_seen;
      send_frame(-1, -1);
      chk("t6_next_valid", fv_seen - fv0, 1);
      chk("t6_count_one", frame_count, 1);

      // randomized frames: good first, then errors, then a free mix
      for (int n = 0; n < 28; n++) begin
         for (int i = 0; i < PL; i++) pay[i] = 8'($urandom);
         if (n < 8)       mode = 0;
         else if (n < 16) mode = 1 + (n % 2);
         else             mode = $urandom_range(0, 4);
         id_check_enable = 1'b1;
         expected_id     = pay[0];
         case (mode)
            1: send_frame($urandom_range(0, PL - 1), -1);
            2: begin expected_id = pay[0] ^ 8'h40; send_frame(-1, -1); end
            3: begin
               id_check_enable = 1'b0; expected_id = pay[0] ^ 8'h01;
               send_frame(-1, -1);
            end
            4: begin send_partial($urandom_range(0, PL)); repeat (T + 3) tick(); end
            default: send_frame(-1, $urandom_range(0, PL - 1));
         endcase
         repeat ($urandom_range(0, 3)) send_byte(8'($urandom), rgap());
      end
      repeat (5) tick();
      chk("sat_small_frames", s_frame_count, 3'd7);
      chk("sat_small_errors", s_error_count, 3'd7);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
